// File: rtl/vga_write_arbiter_if.sv
// Bus bundle between two write requesters, the arbiter and the VGA write port.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface vga_write_arbiter_if;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic [31:0] m0_data;
    logic        m0_ack;
    logic        m0_err;

    logic        m1_req;
    logic [31:0] m1_addr;
    logic [31:0] m1_data;
    logic        m1_ack;
    logic        m1_err;

    logic [31:0] vga_addr;
    logic [31:0] vga_data;
    logic        vga_wr;
    logic        vga_done;

    logic        busy;
    logic        owner;

    modport slave (
        input  m0_req, m0_addr, m0_data,
        input  m1_req, m1_addr, m1_data,
        input  vga_done,
        output m0_ack, m0_err, m1_ack, m1_err,
        output vga_addr, vga_data, vga_wr,
        output busy, owner
    );

    modport master (
        output m0_req, m0_addr, m0_data,
        output m1_req, m1_addr, m1_data,
        output vga_done,
        input  m0_ack, m0_err, m1_ack, m1_err,
        input  vga_addr, vga_data, vga_wr,
        input  busy, owner
    );
endinterface

// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter forwarding single writes from two requesters to one VGA
// write port, with address window check and a bounded wait for completion.
module vga_write_arbiter #(
    parameter logic [31:0] BASE    = 32'h0010_0000,
    parameter logic [31:0] LIMIT   = 32'h0020_0000,
    parameter logic [7:0]  TIMEOUT = 8'd255
) (
    input  logic               clk,
    input  logic               rst,
    vga_write_arbiter_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, state_nxt;

    logic        owner_q, owner_nxt;
    logic [31:0] addr_q, addr_nxt;
    logic [31:0] data_q, data_nxt;
    logic [7:0]  cnt_q, cnt_nxt;
    logic        err_q, err_nxt;

    logic        wr_q, busy_q;
    logic        ack0_q, ack1_q, err0_q, err1_q;

    logic        req_any;
    logic        grant_idx;
    logic [31:0] sel_addr;
    logic [31:0] sel_data;
    logic        in_range;
    logic        timeout_hit;

    // With both requesting, the one not granted last wins; owner holds the last grant.
    always_comb begin
        req_any     = bus.m0_req | bus.m1_req;
        grant_idx   = (bus.m0_req & bus.m1_req) ? ~owner_q : bus.m1_req;
        sel_addr    = grant_idx ? bus.m1_addr : bus.m0_addr;
        sel_data    = grant_idx ? bus.m1_data : bus.m0_data;
        in_range    = (sel_addr >= BASE) && (sel_addr < LIMIT);
        timeout_hit = ({1'b0, cnt_q} + 9'd1) >= {1'b0, TIMEOUT};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_any) state_nxt = in_range ? S_WAIT : S_RESP;
            S_WAIT:  if (bus.vga_done || timeout_hit) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Done wins over a coincident timeout, so it is tested first.
    always_comb begin
        owner_nxt = owner_q;
        addr_nxt  = addr_q;
        data_nxt  = data_q;
        cnt_nxt   = cnt_q;
        err_nxt   = err_q;
        case (state)
            S_IDLE: begin
                if (req_any) begin
                    owner_nxt = grant_idx;
                    addr_nxt  = sel_addr;
                    data_nxt  = sel_data;
                    cnt_nxt   = 8'd0;
                    err_nxt   = ~in_range;
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt_q + 8'd1;
                if (bus.vga_done)     err_nxt = 1'b0;
                else if (timeout_hit) err_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= 1'b1;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
        end else begin
            owner_q <= owner_nxt;
            addr_q  <= addr_nxt;
            data_q  <= data_nxt;
            cnt_q   <= cnt_nxt;
            err_q   <= err_nxt;
            wr_q    <= (state_nxt == S_WAIT);
            busy_q  <= (state_nxt != S_IDLE);
            ack0_q  <= (state_nxt == S_RESP) && !owner_nxt;
            ack1_q  <= (state_nxt == S_RESP) &&  owner_nxt;
            err0_q  <= (state_nxt == S_RESP) && !owner_nxt && err_nxt;
            err1_q  <= (state_nxt == S_RESP) &&  owner_nxt && err_nxt;
        end
    end

    assign bus.vga_addr = addr_q;
    assign bus.vga_data = data_q;
    assign bus.vga_wr   = wr_q;
    assign bus.busy     = busy_q;
    assign bus.owner    = owner_q;
    assign bus.m0_ack   = ack0_q;
    assign bus.m0_err   = err0_q;
    assign bus.m1_ack   = ack1_q;
    assign bus.m1_err   = err1_q;

endmodule

// File: doc/vga_write_arbiter.md
VGA_WRITE_ARBITER -- requirements
Module: vga_write_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-002 The block SHALL have the following parameters, one per line:
- BASE, 32'h0010_0000, lowest address accepted for the VGA window.
- LIMIT, 32'h0020_0000, first address above the VGA window (exclusive).
- TIMEOUT, 8'd255, maximum number of WAIT cycles before the transaction is aborted.
REQ-003 The block SHALL have the following ports, one per line:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- m0_req  in  1  requester 0 write request, held until m0_ack.
- m0_addr  in  32  requester 0 byte address.
- m0_data  in  32  requester 0 write data.
- m0_ack  out  1  one-cycle completion pulse to requester 0.
- m0_err  out  1  qualifies m0_ack: range error or timeout.
- m1_req, m1_addr, m1_data, m1_ack, m1_err  (same as m0_*)  requester 1.
- vga_addr  out  32  latched address to the VGA write port.
- vga_data  out  32  latched data to the VGA write port.
- vga_wr  out  1  write strobe, level, held until vga_done or timeout.
- vga_done  in  1  VGA port completion, sampled only in WAIT.
- busy  out  1  high whenever state is not IDLE.
- owner  out  1  index of the requester currently or last granted.

Function
REQ-004 The FSM SHALL have states IDLE, WAIT and RESP; all outputs are registered.
REQ-005 In IDLE with any req high at a clock edge, the block SHALL grant exactly one requester, latch its addr/data and set owner.
REQ-006 Simultaneous requests SHALL be resolved round-robin: the requester that was not granted last wins. After reset, m0 wins first.
REQ-007 For an in-range address (BASE <= addr < LIMIT, unsigned), the block SHALL go to WAIT, with vga_wr=1 from the cycle after the grant edge.
REQ-008 For an out-of-range address, the block SHALL go directly to RESP with err set; vga_wr SHALL never assert.
REQ-009 In WAIT, the block SHALL hold vga_addr, vga_data and vga_wr=1 stable, and SHALL increment an 8-bit wait counter each cycle.
REQ-010 When vga_done is sampled high in WAIT, the block SHALL go to RESP, drop vga_wr the next cycle, and clear err.
REQ-011 If the wait counter reaches TIMEOUT with vga_done low, the block SHALL go to RESP with err set and drop vga_wr.
REQ-012 If vga_done and the timeout occur on the same edge, the done SHALL take precedence (no err).
REQ-013 RESP SHALL last exactly one cycle: the owner's ack=1 and err as decided, the other requester's ack/err=0; the next state SHALL be IDLE.
REQ-014 Requesters SHALL deassert req at the edge ending the ack cycle; req still high in IDLE is treated as a new request.
REQ-015 Dropping req before ack SHALL NOT cancel a latched transaction; ack still pulses.
REQ-016 vga_done outside WAIT SHALL be ignored; reqs outside IDLE SHALL be ignored (not queued).
REQ-017 Minimum in-range latency SHALL be: grant edge -> vga_wr high -> done sampled -> ack high, i.e. ack 3 cycles after the grant edge when done returns in the first WAIT cycle.

Reset
REQ-018 When rst is sampled high, the block SHALL set state=IDLE; vga_wr, m*_ack, m*_err and busy =0; vga_addr, vga_data and the wait counter =0; owner=1, so that m0 is favoured next.
REQ-019 Reset mid-transaction SHALL abort with no ack; vga_wr SHALL be low in the cycle after the reset edge.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- m0 writes 0x0010_0040/0xDEADBEEF, done after 2 cycles -> vga_addr/data match, vga_wr high 3 cycles, m0_ack=1, m0_err=0, m1_ack=0.
- m0 and m1 request together twice -> grants in order m0, m1, m0, m1; owner toggles.
- m1 writes 0x0020_0000 -> m1_ack with m1_err=1 two cycles after the grant edge; vga_wr stays 0.
- vga_done never returns, TIMEOUT=255 -> vga_wr drops after 255 WAIT cycles; ack+err pulse to the owner.
- rst asserted in WAIT -> no ack; vga_wr=0 next cycle; the next simultaneous request goes to m0.
- vga_done pulse in IDLE, then a request -> the stale done is ignored; vga_wr holds until a fresh done.
